rom_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing the single flash ROM controller among
//   NUM_REQ requesters (e.g. instruction fetch, data load, boot loader). Grants
//   one requester at a time, pulses the controller's load, waits on its ready,

---
 rtl/rom_arbiter_pkg.sv | 27 ++
 rtl/rom_arbiter_if.sv | 28 ++
 rtl/rom_arbiter_rr_picker.sv | 31 +++
 rtl/rom_arbiter.sv | 117 +++++++++++
 tb/tb_rom_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: FSM state encoding, default widths,
// and a constant clog2 helper used to size index and timer registers.
package rom_pkg;

    localparam int DEF_ROM_ADDR = 24;
    localparam int DEF_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    function automatic int rom_clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-controller-side bundle of the arbiter.
// slave = arbiter view, master = environment (requesters + controller) view.
interface rom_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 8,
    parameter int ROM_ADDR = 24
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ROM_ADDR-1:0] req_addr;
    logic [NUM_REQ-1:0]          ack;
    logic [WIDTH-1:0]            rdata;
    logic                        err;
    logic                        busy;
    logic [ROM_ADDR-1:0]         rom_addr;
    logic                        rom_load;
    logic [WIDTH-1:0]            rom_data;
    logic                        rom_ready;

    modport slave (
        input  req, req_addr, rom_data, rom_ready,
        output ack, rdata, err, busy, rom_addr, rom_load
    );

    modport master (
        output req, req_addr, rom_data, rom_ready,
        input  ack, rdata, err, busy, rom_addr, rom_load
    );
endinterface

// File: rtl/rom_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1 with wraparound.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!any && req[wrap_idx(ptr, off)]) begin
                winner = wrap_idx(ptr, off);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sequencer sharing one flash ROM controller among NUM_REQ
// requesters: grant, pulse load, wait for ready (with timeout), return word + ack.
module rom_arbiter
    import rom_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ROM_ADDR = DEF_ROM_ADDR,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus
);

    localparam int IDX_W = rom_clog2(NUM_REQ);
    localparam int TMR_W = rom_clog2(TIMEOUT) + 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ROM_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic [IDX_W-1:0]    winner;
    logic                any;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = winner;
                    addr_d  = bus.req_addr[int'(winner)*ROM_ADDR +: ROM_ADDR];
                    state_d = ISSUE;
                end
            end
            // ready here still reflects the previous access, so it is ignored
            ISSUE: begin
                ptr_d   = grant_q;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.rom_ready) begin
                    rdata_d        = bus.rom_data;
                    err_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rdata_d        = '0;
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                timer_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            timer_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rom_addr = addr_q;
    assign bus.rom_load = (state_q == ISSUE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter with a behavioural ROM controller model
// (page hit latency 2, miss latency 4, optional stall for timeout).
module tb_rom_arbiter;

    localparam int NR = 2;
    localparam int W  = 8;
    localparam int AW = 24;
    localparam int TO = 8;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = NR - 1;
    exp_t exp_q[$];

    rom_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ROM_ADDR(AW)) bus ();

    rom_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ROM_ADDR(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM controller model
    logic          stall;
    int            cnt;
    logic [AW-1:0] la;
    logic [19:0]   last_pg;
    logic          pg_valid;

    function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo ^ 8'h86;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rom_ready <= 1'b0;
            bus.rom_data  <= '0;
            cnt           <= 0;
            pg_valid      <= 1'b0;
            last_pg       <= '0;
            la            <= '0;
        end else if (bus.rom_load) begin
            bus.rom_ready <= 1'b0;
            cnt           <= (pg_valid && last_pg == bus.rom_addr[23:4]) ? 1 : 3;
            last_pg       <= bus.rom_addr[23:4];
            pg_valid      <= 1'b1;
            la            <= bus.rom_addr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !stall) begin
                bus.rom_ready <= 1'b1;
                bus.rom_data  <= rom_word(la);
            end
        end
    end

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int o = 1; o <= NR; o++) begin
            if (r[(p + o) % NR]) return (p + o) % NR;
        end
        return -1;
    endfunction

    task automatic push_req(input int i, input logic [AW-1:0] a, input logic e);
        exp_t x;
        x.idx  = i;
        x.err  = e;
        x.data = e ? 8'h00 : rom_word(a);
        exp_q.push_back(x);
    endtask

    task automatic wait_ack(input int maxc, output int k, output int loads, output int load_k);
        k = 0; loads = 0; load_k = 0;
        while (k < maxc) begin
            @(negedge clk);
            k++;
            if (bus.rom_load) begin
                loads++;
                if (load_k == 0) load_k = k;
            end
            if (bus.ack != '0) return;
        end
        k = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.req_addr = '0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.ack !== 2'b00 || bus.rom_load !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl busy=%b ack=%b load=%b err=%b want 0", bus.busy, bus.ack, bus.rom_load, bus.err);
        end
        total++;
        if (bus.rdata !== 8'h00 || bus.rom_addr !== 24'h0) begin
            bad++;
            $display("FAIL reset_data rdata=%h rom_addr=%h want 0", bus.rdata, bus.rom_addr);
        end
        rst = 1'b0;
        m_ptr = NR - 1;
        @(negedge clk);
    endtask

    task automatic test_single_miss();
        int k, loads, lk;
        exp_t e;
        bus.req_addr[0 +: AW] = 24'h000123;
        bus.req = 2'b01;
        m_ptr = pick(2'b01, m_ptr);
        push_req(0, 24'h000123, 1'b0);
        wait_ack(40, k, loads, lk);
        bus.req = 2'b00;
        e = exp_q.pop_front();
        total++;
        if (k !== 6) begin bad++; $display("FAIL miss_latency got=%0d want=6", k); end
        total++;
        if (loads !== 1 || lk !== 1) begin bad++; $display("FAIL miss_load loads=%0d first=%0d want 1/1", loads, lk); end
        total++;
        if (bus.ack !== 2'b01 || bus.rdata !== 8'hA5 || bus.err !== 1'b0 || e.data !== 8'hA5) begin
            bad++;
            $display("FAIL miss_data ack=%b rdata=%h err=%b want 01/a5/0", bus.ack, bus.rdata, bus.err);
        end
        @(negedge clk);
    endtask

    task automatic test_page_hit();
        int k, loads, lk;
        exp_t e;
        logic [AW-1:0] addrs [2];
        addrs[0] = 24'h000120;
        addrs[1] = 24'h000124;
        for (int n = 0; n < 2; n++) begin
            bus.req_addr[0 +: AW] = addrs[n];
            bus.req = 2'b01;
            m_ptr = pick(2'b01, m_ptr);
            push_req(0, addrs[n], 1'b0);
            wait_ack(40, k, loads, lk);
            bus.req = 2'b00;
            e = exp_q.pop_front();
            total++;
            if (bus.ack !== (2'b01 << e.idx) || bus.rdata !== e.data || bus.err !== e.err) begin
                bad++;
                $display("FAIL hit_data%0d ack=%b rdata=%h err=%b want idx=%0d data=%h", n, bus.ack, bus.rdata, bus.err, e.idx, e.data);
            end
            @(negedge clk);
        end
        total++;
        if (k !== 4) begin bad++; $display("FAIL hit_latency got=%0d want=4", k); end
    endtask

    task automatic test_contention();
        int k, loads, lk, prev;
        exp_t e;
        bus.req_addr[0 +: AW]  = 24'h000200;
        bus.req_addr[AW +: AW] = 24'h000310;
        bus.req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            m_ptr = pick(2'b11, m_ptr);
            push_req(m_ptr, m_ptr == 0 ? 24'h000200 : 24'h000310, 1'b0);
        end
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            wait_ack(40, k, loads, lk);
            if (n == 3) bus.req = 2'b00;
            e = exp_q.pop_front();
            total++;
            if (k < 0 || bus.ack !== (2'b01 << e.idx) || bus.rdata !== e.data) begin
                bad++;
                $display("FAIL contention%0d ack=%b rdata=%h want idx=%0d data=%h", n, bus.ack, bus.rdata, e.idx, e.data);
            end
            total++;
            if (e.idx == prev || !$onehot(bus.ack)) begin
                bad++;
                $display("FAIL contention_fair%0d ack=%b prev=%0d", n, bus.ack, prev);
            end
            prev = e.idx;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int k, loads, lk;
        exp_t e;
        stall = 1'b1;
        bus.req_addr[0 +: AW] = 24'h000055;
        bus.req = 2'b01;
        m_ptr = pick(2'b01, m_ptr);
        push_req(0, 24'h000055, 1'b1);
        wait_ack(40, k, loads, lk);
        bus.req = 2'b00;
        e = exp_q.pop_front();
        total++;
        if (k !== 2 + TO || lk !== 1) begin bad++; $display("FAIL timeout_latency got=%0d load=%0d want=%0d/1", k, lk, 2 + TO); end
        total++;
        if (bus.ack !== (2'b01 << e.idx) || bus.err !== 1'b1 || bus.rdata !== 8'h00) begin
            bad++;
            $display("FAIL timeout_err ack=%b err=%b rdata=%h want 01/1/00", bus.ack, bus.err, bus.rdata);
        end
        stall = 1'b0;
        @(negedge clk);
        bus.req_addr[0 +: AW] = 24'h000400;
        bus.req = 2'b01;
        m_ptr = pick(2'b01, m_ptr);
        push_req(0, 24'h000400, 1'b0);
        wait_ack(40, k, loads, lk);
        bus.req = 2'b00;
        e = exp_q.pop_front();
        total++;
        if (k !== 6 || bus.err !== 1'b0 || bus.rdata !== e.data) begin
            bad++;
            $display("FAIL after_timeout k=%0d err=%b rdata=%h want 6/0/%h", k, bus.err, bus.rdata, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int extra;
        int k;
        exp_t e;
        bus.req_addr[AW +: AW] = 24'h000777;
        bus.req = 2'b10;
        m_ptr = pick(2'b10, m_ptr);
        push_req(1, 24'h000777, 1'b0);
        repeat (3) @(negedge clk);
        bus.req = 2'b00;
        k = 3;
        while (k < 40 && bus.ack == '0) begin
            @(negedge clk);
            k++;
        end
        e = exp_q.pop_front();
        total++;
        if (bus.ack !== (2'b01 << e.idx) || bus.rdata !== e.data) begin
            bad++;
            $display("FAIL early_drop_ack ack=%b rdata=%h want 10/%h", bus.ack, bus.rdata, e.data);
        end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL early_drop_idle busy=%b want 0", bus.busy); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack != '0) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL early_drop_once extra_acks=%0d want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int extra;
        bus.req_addr[0 +: AW] = 24'h000900;
        bus.req = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.ack !== 2'b00 || bus.rom_load !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid busy=%b ack=%b load=%b want 0", bus.busy, bus.ack, bus.rom_load);
        end
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = NR - 1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ack != '0 || bus.busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL reset_no_ack stray_cycles=%0d want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_page_hit();
        test_contention();
        test_timeout();
        test_early_drop();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
